dl_mem_arbiter: RTL and testbench

DL_MEM_ARBITER -- requirements
Module: dl_mem_arbiter

---
 rtl/ht1080z_pkg.sv | 20 ++
 rtl/dl_fifo.sv | 57 +++++
 rtl/dl_mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_dl_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ht1080z_pkg.sv
// Shared types for the HT1080Z memory subsystem: arbiter FSM states,
// grant sources and the default cassette-image base offset.
package ht1080z_pkg;

  // Download files with a non-zero index are placed above this offset.
  localparam logic [24:0] CAS_BASE_DEF = 25'h0010000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_DL  = 2'd0,
    GNT_VID = 2'd1,
    GNT_CPU = 2'd2
  } gnt_src_e;

endpackage

// File: rtl/dl_fifo.sv
// Download write buffer: a small power-of-two FIFO of {addr,data} entries.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module dl_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];

  // Entry storage.
  // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dl_mem_arbiter.sv
// Single-port memory arbiter: download FIFO writes have absolute priority,
// video and CPU share the remaining bandwidth round-robin. One transaction
// at a time: IDLE (grant) -> ISSUE (mem_req) -> WAIT (until mem_ack).
module dl_mem_arbiter
  import ht1080z_pkg::*;
#(
  parameter int                ADDR_W     = 25,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] CAS_BASE   = ADDR_W'(CAS_BASE_DEF)
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dn_go,
  input  logic              dn_wr,
  input  logic [13:0]       dn_addr,
  input  logic [7:0]        dn_idx,
  input  logic [7:0]        dn_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [7:0]        cpu_dout,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_dout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout,
  output logic              dl_done,
  output logic              dl_ovf
);

  localparam int PW = ADDR_W + 8;

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  gnt_src_e          r_gnt;
  gnt_src_e          w_gnt_nxt;
  gnt_src_e          r_rr_last;
  logic              w_grant;

  logic [ADDR_W-1:0] w_dn_ext;
  logic [ADDR_W-1:0] w_map_addr;
  logic [PW-1:0]     w_fifo_rdata;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_fifo_pop;
  logic              w_done_ack;
  logic              w_serving_dl;
  logic              w_drop;

  logic [ADDR_W-1:0] w_sel_addr;
  logic [7:0]        w_sel_din;
  logic              w_sel_we;

  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_din;
  logic              r_mem_we;
  logic              r_cpu_ack;
  logic              r_vid_ack;
  logic [7:0]        r_cpu_dout;
  logic [7:0]        r_vid_dout;
  logic              r_dn_go_q;
  logic              r_dl_ovf;
  logic              r_dl_pend;

  // Download address mapping: index 0 is loaded as-is, other files above CAS_BASE.
  assign w_dn_ext   = ADDR_W'(dn_addr);
  assign w_map_addr = (dn_idx == 8'd0) ? w_dn_ext : w_dn_ext + CAS_BASE;

  assign w_done_ack   = (r_state == ST_WAIT) && mem_ack;
  assign w_fifo_pop   = w_done_ack && (r_gnt == GNT_DL);
  assign w_serving_dl = (r_state != ST_IDLE) && (r_gnt == GNT_DL);
  assign w_drop       = dn_wr && w_fifo_full && !w_fifo_pop;

  dl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PW)
  ) u_dl_fifo (
    .i_clk   (clk_sys),
    .i_rst_n (reset_n),
    .i_push  (dn_wr),
    .i_wdata ({w_map_addr, dn_data}),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Next-state and grant selection; the grant is decided in IDLE only.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_grant     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_grant   = 1'b1;
          w_gnt_nxt = GNT_DL;
        end else if (vid_req && cpu_req) begin
          w_grant   = 1'b1;
          w_gnt_nxt = (r_rr_last == GNT_CPU) ? GNT_VID : GNT_CPU;
        end else if (vid_req) begin
          w_grant   = 1'b1;
          w_gnt_nxt = GNT_VID;
        end else if (cpu_req) begin
          w_grant   = 1'b1;
          w_gnt_nxt = GNT_CPU;
        end
        if (w_grant) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (mem_ack) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Command fields for the source about to be granted.
  always_comb begin
    w_sel_addr = cpu_addr;
    w_sel_din  = cpu_din;
    w_sel_we   = cpu_we;
    unique case (w_gnt_nxt)
      GNT_DL: begin
        w_sel_addr = w_fifo_rdata[PW-1:8];
        w_sel_din  = w_fifo_rdata[7:0];
        w_sel_we   = 1'b1;
      end
      GNT_VID: begin
        w_sel_addr = vid_addr;
        w_sel_din  = 8'h00;
        w_sel_we   = 1'b0;
      end
      default: ;
    endcase
  end

  // FSM state, current grant and round-robin history (last CPU/video winner).
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= GNT_DL;
      r_rr_last <= GNT_CPU;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt <= w_gnt_nxt;
        if (w_gnt_nxt != GNT_DL) r_rr_last <= w_gnt_nxt;
      end
    end
  end

  // Memory command registers: loaded at grant, held through ISSUE and WAIT.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_we   <= 1'b0;
    end else if (w_grant) begin
      r_mem_addr <= w_sel_addr;
      r_mem_din  <= w_sel_din;
      r_mem_we   <= w_sel_we;
    end
  end

  // Requester acks and read data, registered one cycle after mem_ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_ack  <= 1'b0;
      r_vid_ack  <= 1'b0;
      r_cpu_dout <= '0;
      r_vid_dout <= '0;
    end else begin
      r_cpu_ack <= w_done_ack && (r_gnt == GNT_CPU);
      r_vid_ack <= w_done_ack && (r_gnt == GNT_VID);
      if (w_done_ack && (r_gnt == GNT_CPU)) r_cpu_dout <= mem_dout;
      if (w_done_ack && (r_gnt == GNT_VID)) r_vid_dout <= mem_dout;
    end
  end

  // Download status: sticky overflow cleared on a new download, and a pending
  // flag that arms dl_done once dn_go has been seen high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dn_go_q <= 1'b0;
      r_dl_ovf  <= 1'b0;
      r_dl_pend <= 1'b0;
    end else begin
      r_dn_go_q <= dn_go;
      if (w_drop)                  r_dl_ovf <= 1'b1;
      else if (dn_go && !r_dn_go_q) r_dl_ovf <= 1'b0;
      if (dn_go)        r_dl_pend <= 1'b1;
      else if (dl_done) r_dl_pend <= 1'b0;
    end
  end

  assign dl_done  = r_dl_pend && !dn_go && w_fifo_empty && !w_serving_dl;
  assign dl_ovf   = r_dl_ovf;
  assign mem_req  = (r_state == ST_ISSUE);
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign cpu_ack  = r_cpu_ack;
  assign cpu_dout = r_cpu_dout;
  assign vid_ack  = r_vid_ack;
  assign vid_dout = r_vid_dout;

endmodule

// File: tb/tb_dl_mem_arbiter.sv
// Directed, scoreboard-based bench for dl_mem_arbiter with a behavioural
// memory of programmable latency.
module tb_dl_mem_arbiter;

  typedef struct {
    logic       is_vid;
    logic       chk_data;
    logic [7:0] data;
  } ack_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        dn_go = 1'b0, dn_wr = 1'b0;
  logic [13:0] dn_addr = '0;
  logic [7:0]  dn_idx = '0, dn_data = '0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_dout;
  logic        vid_req = 1'b0;
  logic [24:0] vid_addr = '0;
  logic        vid_ack;
  logic [7:0]  vid_dout;
  logic        mem_req, mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic        dl_done, dl_ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 2;
  int mem_cnt  = 0;
  int req_cyc  = -100;
  int ack_cyc  = -100;
  int n_done   = 0;
  int chk_done_time = 0;
  logic [24:0] pend_addr = '0;

  ack_t ack_q[$];
  wr_t  wr_q[$];

  dl_mem_arbiter dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .dn_go    (dn_go),
    .dn_wr    (dn_wr),
    .dn_addr  (dn_addr),
    .dn_idx   (dn_idx),
    .dn_data  (dn_data),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_ack  (cpu_ack),
    .cpu_dout (cpu_dout),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_ack  (vid_ack),
    .vid_dout (vid_dout),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_ack  (mem_ack),
    .mem_dout (mem_dout),
    .dl_done  (dl_done),
    .dl_ovf   (dl_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Read contents of the behavioural memory.
  function automatic logic [7:0] rd_model(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_ack(input logic is_vid, input logic chk, input logic [7:0] d);
    ack_t e;
    e.is_vid = is_vid; e.chk_data = chk; e.data = d;
    ack_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [24:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic dn_strobe(input logic [7:0] idx, input logic [13:0] a, input logic [7:0] d);
    dn_idx = idx; dn_addr = a; dn_data = d; dn_wr = 1'b1;
    @(negedge clk_sys);
    dn_wr = 1'b0;
  endtask

  task automatic cpu_pulse(input logic we, input logic [24:0] a, input logic [7:0] d);
    cpu_we = we; cpu_addr = a; cpu_din = d; cpu_req = 1'b1;
    @(negedge clk_sys);
    cpu_req = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int max_cyc);
    int k = 0;
    while ((ack_q.size() != 0 || wr_q.size() != 0 || mem_cnt != 0) && k < max_cyc) begin
      @(negedge clk_sys);
      k++;
    end
    check({tag, "_drain"}, 32'(k < max_cyc), 32'd1);
    repeat (3) @(negedge clk_sys);
  endtask

  // Memory model: acks 'lat' cycles after mem_req, checks every write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk_sys);
      mem_ack = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_ack  = 1'b1;
          mem_dout = rd_model(pend_addr);
          ack_cyc  = cyc;
        end
      end
      if (mem_req) begin
        req_cyc   = cyc;
        mem_cnt   = lat;
        pend_addr = mem_addr;
        if (mem_we) begin
          if (wr_q.size() == 0) check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
          else begin
            w = wr_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(w.addr));
            check("wr_data", 32'(mem_din), 32'(w.data));
          end
        end
      end
    end
  end

  // Output monitor, sampling just before each rising edge.
  initial begin
    ack_t e;
    forever begin
      @(negedge clk_sys);
      #4;
      if (cpu_ack || vid_ack) begin
        if (ack_q.size() == 0) check("unexpected_ack", 32'({cpu_ack, vid_ack}), 32'd0);
        else begin
          e = ack_q.pop_front();
          check("ack_is_vid", 32'(vid_ack), 32'(e.is_vid));
          check("ack_is_cpu", 32'(cpu_ack), 32'(!e.is_vid));
          if (e.chk_data) check("ack_data", 32'(e.is_vid ? vid_dout : cpu_dout), 32'(e.data));
          check("ack_latency", 32'(cyc - req_cyc), 32'(lat + 1));
        end
      end
      if (dl_done) begin
        n_done++;
        if (chk_done_time != 0) check("dl_done_time", 32'(cyc), 32'(ack_cyc + 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int k;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_mem_req",  32'(mem_req),  32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din",  32'(mem_din),  32'd0);
    check("rst_cpu_ack",  32'(cpu_ack),  32'd0);
    check("rst_vid_ack",  32'(vid_ack),  32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("rst_vid_dout", 32'(vid_dout), 32'd0);
    check("rst_dl_done",  32'(dl_done),  32'd0);
    check("rst_dl_ovf",   32'(dl_ovf),   32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Download index 0: address passes through unchanged.
    lat = 2;
    dn_go = 1'b1;
    @(negedge clk_sys);
    exp_wr(25'h0000123, 8'hA5);
    dn_strobe(8'd0, 14'h0123, 8'hA5);
    wait_quiet("dn_idx0", 50);

    // Download index 1: offset by CAS_BASE.
    exp_wr(25'h0010010, 8'h3C);
    dn_strobe(8'd1, 14'h0010, 8'h3C);
    wait_quiet("dn_idx1", 50);

    // End of download with an empty buffer: one dl_done pulse.
    n_done = 0;
    dn_go = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("dl_done_once_a", 32'(n_done), 32'd1);
    check("ovf_clear_a", 32'(dl_ovf), 32'd0);

    // CPU read with request dropped after one cycle still completes.
    exp_ack(1'b0, 1'b1, rd_model(25'h00ABCDE));
    cpu_pulse(1'b0, 25'h00ABCDE, 8'h00);
    wait_quiet("cpu_rd", 50);

    // Video read at the top of the address space.
    exp_ack(1'b1, 1'b1, rd_model(25'h1FFFFFF));
    vid_addr = 25'h1FFFFFF; vid_req = 1'b1;
    @(negedge clk_sys);
    vid_req = 1'b0;
    wait_quiet("vid_rd", 50);
    check("cpu_dout_hold", 32'(cpu_dout), 32'(rd_model(25'h00ABCDE)));

    // CPU write goes to memory and is acknowledged.
    exp_wr(25'h1000055, 8'h77);
    exp_ack(1'b0, 1'b0, 8'h00);
    cpu_pulse(1'b1, 25'h1000055, 8'h77);
    cpu_we = 1'b0;
    wait_quiet("cpu_wr", 50);
    check("vid_dout_hold", 32'(vid_dout), 32'(rd_model(25'h1FFFFFF)));

    // Both requesters held, latency 3: acks alternate starting with video.
    lat = 3;
    vid_addr = 25'h01F0F0F;
    cpu_addr = 25'h002468A;
    cpu_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_ack(1'b1, 1'b1, rd_model(25'h01F0F0F));
      exp_ack(1'b0, 1'b1, rd_model(25'h002468A));
    end
    vid_req = 1'b1; cpu_req = 1'b1;
    seen = 0; k = 0;
    while (seen < 4 && k < 200) begin
      @(negedge clk_sys);
      k++;
      if (cpu_ack || vid_ack) seen++;
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    check("rr_ack_count", 32'(seen), 32'd4);
    wait_quiet("rr", 50);

    // Six back-to-back download bytes, latency 4: four survive, overflow set.
    lat = 4;
    dn_go = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 4; i++) exp_wr(25'h0000200 + 25'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 6; i++) dn_strobe(8'd0, 14'h0200 + 14'(i), 8'h10 + 8'(i));
    wait_quiet("ovf", 100);
    check("ovf_set", 32'(dl_ovf), 32'd1);
    n_done = 0;
    dn_go = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("dl_done_once_b", 32'(n_done), 32'd1);
    check("ovf_sticky", 32'(dl_ovf), 32'd1);

    // Reset in the middle of WAIT; the late mem_ack must be ignored.
    cpu_pulse(1'b0, 25'h0012345, 8'h00);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("mid_rst_mem_req",  32'(mem_req),  32'd0);
    check("mid_rst_mem_we",   32'(mem_we),   32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_mem_din",  32'(mem_din),  32'd0);
    check("mid_rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("mid_rst_vid_dout", 32'(vid_dout), 32'd0);
    check("mid_rst_dl_ovf",   32'(dl_ovf),   32'd0);
    check("mid_rst_dl_done",  32'(dl_done),  32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk_sys);
      if (mem_req || cpu_ack || vid_ack) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);
    check("post_rst_cpu_dout", 32'(cpu_dout), 32'd0);
    exp_ack(1'b0, 1'b1, rd_model(25'h0054321));
    cpu_pulse(1'b0, 25'h0054321, 8'h00);
    wait_quiet("post_rst_rd", 50);

    // Download of three bytes at a CAS file index; dn_go drops with all queued.
    lat = 2;
    dn_go = 1'b1;
    @(negedge clk_sys);
    check("ovf_clr_on_go", 32'(dl_ovf), 32'd0);
    exp_wr(25'h0013FFD, 8'hC1);
    exp_wr(25'h0013FFE, 8'hC2);
    exp_wr(25'h0013FFF, 8'hC3);
    dn_strobe(8'd2, 14'h3FFD, 8'hC1);
    dn_strobe(8'd2, 14'h3FFE, 8'hC2);
    dn_strobe(8'd2, 14'h3FFF, 8'hC3);
    n_done = 0;
    chk_done_time = 1;
    dn_go = 1'b0;
    wait_quiet("done_drain", 100);
    repeat (3) @(negedge clk_sys);
    chk_done_time = 0;
    check("dl_done_once_c", 32'(n_done), 32'd1);

    check("ack_q_empty", 32'(ack_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
